// File: rtl/uart_receiver.sv
// uart_receiver
//   Oversampled asynchronous serial receiver (8N2 by default). The serial
//   line is synchronized, the start bit is confirmed at its mid-point, and
//   every following bit is sampled once per NB_OVS ticks, i.e. mid-bit.
//   Framed bytes are presented with a one-cycle o_valid pulse; a frame whose
//   stop bit(s) sample low produces a one-cycle o_error pulse instead.
//
// Parameters
//   NB_DATA : data bits per frame
//   NB_STOP : stop bits per frame
//   NB_OVS  : i_tick pulses per bit period
//
// Ports
//   i_clk   in   1        clock, all state updates on the rising edge
//   i_reset in   1        synchronous reset, active low
//   i_tick  in   1        oversampling strobe, one i_clk cycle wide
//   i_rx    in   1        serial line, idle high, asynchronous to i_clk
//   o_data  out  NB_DATA  last correctly framed byte, LSB = first bit received
//   o_valid out  1        one-cycle pulse, o_data updated this cycle
//   o_error out  1        one-cycle pulse, framing error
module uart_receiver #(
  parameter int NB_DATA = 8,
  parameter int NB_STOP = 2,
  parameter int NB_OVS  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_error
);

  localparam int NB_CNT = (NB_OVS > 1) ? $clog2(NB_OVS) : 1;
  localparam int NB_MAX = (NB_DATA > NB_STOP) ? NB_DATA : NB_STOP;
  localparam int NB_IDX = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;

  localparam logic [NB_CNT-1:0] CNT_MID       = NB_CNT'(NB_OVS / 2 - 1);
  localparam logic [NB_CNT-1:0] CNT_LAST      = NB_CNT'(NB_OVS - 1);
  localparam logic [NB_IDX-1:0] IDX_DATA_LAST = NB_IDX'(NB_DATA - 1);
  localparam logic [NB_IDX-1:0] IDX_STOP_LAST = NB_IDX'(NB_STOP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic               rx_meta_reg;
  logic               rx_s_reg;
  state_t             state_reg, state_next;
  logic [NB_CNT-1:0]  cnt_reg, cnt_next;
  logic [NB_IDX-1:0]  idx_reg, idx_next;
  logic [NB_DATA-1:0] shift_reg, shift_next;
  logic               err_reg, err_next;
  logic [NB_DATA-1:0] data_reg, data_next;
  logic               valid_reg, valid_next;
  logic               error_reg, error_next;

  // New sample enters at the MSB; after NB_DATA shifts the first bit sits at LSB.
  logic [NB_DATA:0]   shift_in;
  // Error status including the stop-bit sample being taken right now.
  logic               stop_err;

  assign shift_in = {rx_s_reg, shift_reg};
  assign stop_err = err_reg | ~rx_s_reg;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      err_reg     <= 1'b0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      rx_meta_reg <= i_rx;
      rx_s_reg    <= rx_meta_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      shift_reg   <= shift_next;
      err_reg     <= err_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      error_reg   <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    err_next   = err_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    error_next = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        err_next = 1'b0;
        if (!rx_s_reg) begin
          state_next = START;
        end
      end

      START: begin
        if (i_tick) begin
          if (cnt_reg == CNT_MID) begin
            cnt_next = '0;
            idx_next = '0;
            // A line that is high again at mid start bit was only a glitch.
            state_next = rx_s_reg ? IDLE : DATA;
          end else begin
            cnt_next = cnt_reg + NB_CNT'(1);
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            shift_next = shift_in[NB_DATA:1];
            if (idx_reg == IDX_DATA_LAST) begin
              idx_next   = '0;
              err_next   = 1'b0;
              state_next = STOP;
            end else begin
              idx_next = idx_reg + NB_IDX'(1);
            end
          end else begin
            cnt_next = cnt_reg + NB_CNT'(1);
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            err_next = stop_err;
            // Leaving at mid last stop bit leaves half a bit to catch the
            // next start edge of a back-to-back frame.
            if (idx_reg == IDX_STOP_LAST) begin
              idx_next   = '0;
              state_next = IDLE;
              if (stop_err) begin
                error_next = 1'b1;
              end else begin
                valid_next = 1'b1;
                data_next  = shift_reg;
              end
            end else begin
              idx_next = idx_reg + NB_IDX'(1);
            end
          end else begin
            cnt_next = cnt_reg + NB_CNT'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
        err_next   = 1'b0;
      end
    endcase
  end

  assign o_data  = data_reg;
  assign o_valid = valid_reg;
  assign o_error = error_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Directed bench for uart_receiver (8 data bits, 2 stop bits, 16 ticks per
//   bit, one tick every 4 clocks). Each transmitted frame is reduced by a
//   frame-level model to an expected event (good byte or framing error)
//   queued in order; a negedge compare process matches every output pulse
//   against that queue and checks o_data against the last good byte on
//   every cycle. Literal expectations after each scenario pin the model.
module tb_uart_receiver;

  logic       clk;
  logic       i_reset;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_error;

  int n_compared   = 0;
  int n_mismatched = 0;
  int valid_seen   = 0;
  int error_seen   = 0;

  // Expected events: bit 8 = framing error, bits 7:0 = byte for good frames.
  logic [8:0] exp_q[$];
  logic [7:0] model_data;
  logic       tick_en;

  uart_receiver #(
    .NB_DATA(8),
    .NB_STOP(2),
    .NB_OVS (16)
  ) dut (
    .i_clk  (clk),
    .i_reset(i_reset),
    .i_tick (i_tick),
    .i_rx   (i_rx),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_error(o_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every 4 clocks while enabled.
  initial begin
    logic [1:0] div;
    div    = 2'd0;
    i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div    = div + 2'd1;
      i_tick = tick_en && (div == 2'd0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the event queue and held byte.
  always @(negedge clk) begin
    if (i_reset) begin
      n_compared++;
      if (o_valid && o_error) begin
        n_mismatched++;
        $display("FAIL both_pulses: o_valid=%0b o_error=%0b, required not both", o_valid, o_error);
      end
      if (o_valid || o_error) begin
        logic [8:0] e;
        if (o_valid) valid_seen++;
        if (o_error) error_seen++;
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++;
          $display("FAIL unexpected_pulse: valid=%0b error=%0b data=%0h, required no pulse",
                   o_valid, o_error, o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_error !== e[8]) begin
            n_mismatched++;
            $display("FAIL pulse_kind: error=%0b, required error=%0b", o_error, e[8]);
          end else if (!e[8]) begin
            model_data = e[7:0];
          end
        end
      end
      n_compared++;
      if (o_data !== model_data) begin
        n_mismatched++;
        $display("FAIL o_data_hold: got %0h, required %0h", o_data, model_data);
      end
    end
  end

  // Holds the line at b for nticks ticks as seen by the DUT's sampling edges.
  task automatic send_bit(input logic b, input int nticks);
    int n;
    i_rx = b;
    n = 0;
    while (n < nticks) begin
      @(posedge clk);
      if (i_tick) n++;
    end
    #1;
  endtask

  // stop_mask bit k = level of stop bit k; pause_bit = data bit index in
  // which ticks are suspended for 100 clocks (-1: none).
  task automatic send_frame(input logic [7:0] data, input logic [1:0] stop_mask,
                            input int pause_bit);
    if (&stop_mask) exp_q.push_back({1'b0, data});
    else            exp_q.push_back({1'b1, data});
    send_bit(1'b0, 16);
    for (int k = 0; k < 8; k++) begin
      if (k == pause_bit) begin
        send_bit(data[k], 8);
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        tick_en = 1'b1;
        send_bit(data[k], 8);
      end else begin
        send_bit(data[k], 16);
      end
    end
    send_bit(stop_mask[0], 16);
    send_bit(stop_mask[1], 16);
    i_rx = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    i_reset = 1'b0;
    i_rx    = 1'b1;
    exp_q.delete();
    model_data = 8'h00;
    repeat (cycles) @(posedge clk);
    #1;
    check("reset_o_data", {24'd0, o_data}, 32'h00);
    check("reset_o_valid", {31'd0, o_valid}, 32'h0);
    check("reset_o_error", {31'd0, o_error}, 32'h0);
    i_reset = 1'b1;
  endtask

  initial begin
    int v0;
    int e0;
    logic [7:0] d55;
    i_reset    = 1'b0;
    i_rx       = 1'b1;
    tick_en    = 1'b1;
    model_data = 8'h00;

    do_reset(5);
    send_bit(1'b1, 20);

    // Single good frame.
    v0 = valid_seen; e0 = error_seen;
    send_frame(8'hA5, 2'b11, -1);
    send_bit(1'b1, 4);
    check("a5_data", {24'd0, o_data}, 32'hA5);
    check("a5_valid_count", valid_seen - v0, 1);
    check("a5_error_count", error_seen - e0, 0);

    // Short low glitch on the line: rejected at mid start bit.
    v0 = valid_seen; e0 = error_seen;
    send_bit(1'b0, 3);
    send_bit(1'b1, 40);
    check("glitch_data", {24'd0, o_data}, 32'hA5);
    check("glitch_pulses", (valid_seen - v0) + (error_seen - e0), 0);

    // Framing error on the first stop bit.
    v0 = valid_seen; e0 = error_seen;
    send_frame(8'h3C, 2'b10, -1);
    send_bit(1'b1, 8);
    check("ferr_error_count", error_seen - e0, 1);
    check("ferr_valid_count", valid_seen - v0, 0);
    check("ferr_data_held", {24'd0, o_data}, 32'hA5);

    // Back-to-back frames with no idle gap.
    v0 = valid_seen;
    send_frame(8'h00, 2'b11, -1);
    check("b2b_first_data", {24'd0, o_data}, 32'h00);
    send_frame(8'hFF, 2'b11, -1);
    send_bit(1'b1, 8);
    check("b2b_second_data", {24'd0, o_data}, 32'hFF);
    check("b2b_valid_count", valid_seen - v0, 2);

    // Reset in the middle of data bit 4 of 0x55, then a clean frame.
    d55 = 8'h55;
    send_bit(1'b0, 16);
    for (int k = 0; k < 4; k++) send_bit(d55[k], 16);
    send_bit(d55[4], 8);
    do_reset(4);
    send_bit(1'b1, 20);
    v0 = valid_seen; e0 = error_seen;
    send_frame(8'h81, 2'b11, -1);
    send_bit(1'b1, 8);
    check("post_reset_data", {24'd0, o_data}, 32'h81);
    check("post_reset_valid_count", valid_seen - v0, 1);
    check("post_reset_error_count", error_seen - e0, 0);

    // Ticks suspended for 100 clocks inside data bit 3.
    v0 = valid_seen;
    send_frame(8'h6B, 2'b11, 3);
    send_bit(1'b1, 8);
    check("pause_data", {24'd0, o_data}, 32'h6B);
    check("pause_valid_count", valid_seen - v0, 1);

    // Break: line low for 385 ticks. Frames restart immediately after each
    // error (168 ticks per frame), so two errors occur, and the third frame
    // sees data bits 0-1 low and bits 2-7 high once the line returns high.
    v0 = valid_seen; e0 = error_seen;
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b0, 8'hFC});
    send_bit(1'b0, 385);
    send_bit(1'b1, 200);
    check("break_error_count", error_seen - e0, 2);
    check("break_valid_count", valid_seen - v0, 1);
    check("break_data", {24'd0, o_data}, 32'hFC);

    check("pending_events", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL expose parameter NB_DATA, default 8, data bits per frame.
REQ-002 SHALL expose parameter NB_STOP, default 2, stop bits per frame.
REQ-003 SHALL expose parameter NB_OVS, default 16, i_tick pulses per bit period.
REQ-004 SHALL have port i_clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_tick  input  1  oversampling strobe, one i_clk cycle wide, NB_OVS per bit.
REQ-007 SHALL have port i_rx  input  1  serial line, idle high, asynchronous to i_clk.
REQ-008 SHALL have port o_data  output  NB_DATA  last correctly framed byte, LSB = first received bit.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse, o_data updated this cycle.
REQ-010 SHALL have port o_error  output  1  one-cycle pulse, framing error (stop bit sampled low).

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP; all outputs registered.
REQ-013 SHALL count ticks with a counter cnt of width clog2(NB_OVS), advancing only on cycles with i_tick=1; no tick = no state change.
REQ-014 IDLE: cnt=0; on rx_s=0 go START (no tick needed).
REQ-015 START: on tick with cnt==NB_OVS/2-1 (7), if rx_s=0 clear cnt, clear bit index, go DATA; if rx_s=1 go IDLE with no output (glitch reject).
REQ-016 DATA: on tick with cnt==NB_OVS-1, shift rx_s into shift register MSB (right shift, LSB-first reception), clear cnt; after NB_DATA samples clear bit index, go STOP.
REQ-017 STOP: on tick with cnt==NB_OVS-1, sample rx_s, clear cnt; any low sample sets a sticky frame-error flag; after NB_STOP samples go IDLE.
REQ-018 On the STOP->IDLE transition with no error: load o_data from shift register, o_valid=1 for exactly the next cycle.
REQ-019 On the STOP->IDLE transition with error: o_error=1 for exactly the next cycle, o_valid stays 0, o_data holds previous value.
REQ-020 o_valid and o_error SHALL never be high simultaneously and SHALL be 0 in every other cycle.
REQ-021 o_data SHALL change only in the cycle o_valid rises; held otherwise.
REQ-022 Receiver returns to IDLE at mid-point of the last stop bit, so a start bit immediately following the stop bits is detected.
REQ-023 If rx_s stays low after a framing error, IDLE SHALL re-enter START immediately (break condition yields repeated o_error frames).
REQ-024 Counters, bit index and error flag SHALL be cleared on every state entry; no wrap beyond NB_OVS-1 or NB_DATA-1.
REQ-025 Illegal state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-026 While i_reset=0 at a rising edge: state=IDLE, cnt=0, bit index=0, shift register=0, error flag=0, synchronizer flops=1, o_data=0, o_valid=0, o_error=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no o_valid/o_error pulse; reception resumes with the next falling edge after release.

Verification
REQ-028 Frame 0xA5, NB_STOP=2, tick every 4 clocks -> exactly one o_valid pulse, o_data=0xA5, o_error=0 throughout.
REQ-029 i_rx low for 3 ticks then high -> state back to IDLE, no o_valid, no o_error, o_data unchanged.
REQ-030 Frame 0x3C with first stop bit driven 0 -> one o_error pulse, no o_valid, o_data keeps prior value.
REQ-031 Back-to-back frames 0x00 then 0xFF with no idle gap -> two o_valid pulses, o_data=0x00 then 0xFF.
REQ-032 i_reset=0 during data bit 4 of frame 0x55, released, then frame 0x81 -> no output for 0x55, one o_valid with o_data=0x81.
REQ-033 i_tick held 0 for 100 cycles mid-frame -> state and cnt frozen; frame completes correctly once ticks resume.
